// File: rtl/ps2_pkg.sv
// PS/2 Set-2 byte constants, key identifier type and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_NUL    = 8'h00;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR    = 8'hFF;

  localparam int unsigned KEY_ID_W = 9;

  // {ext, code}: extended and plain keys with the same code are distinct keys
  typedef logic [KEY_ID_W-1:0] key_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

  // Status/pause bytes that never form part of a key sequence
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {PS2_PAUSE, PS2_NUL, PS2_BAT_OK, PS2_ECHO,
                     PS2_ACK, PS2_RESEND, PS2_ERR};
  endfunction

endpackage

// File: rtl/ps2_key_table.sv
// Held-key table: per-entry valid+id, combinational lookup, insert/remove, count.
module ps2_key_table
  import ps2_pkg::*;
#(
  parameter int unsigned MAX_KEYS = 4,
  parameter int unsigned IDX_W    = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1,
  parameter int unsigned CNT_W    = $clog2(MAX_KEYS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  key_id_t          lookup_id,
  output logic             hit_c,
  output logic [IDX_W-1:0] hit_idx_c,
  output logic             free_c,
  output logic [IDX_W-1:0] free_idx_c,
  input  logic             insert,
  input  logic [IDX_W-1:0] insert_idx,
  input  key_id_t          insert_id,
  input  logic             remove,
  input  logic [IDX_W-1:0] remove_idx,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next_c
);

  logic [MAX_KEYS-1:0] valid;
  key_id_t             ids [MAX_KEYS];

  // Lookup: scan downward so the lowest matching / free index wins
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int i = int'(MAX_KEYS) - 1; i >= 0; i--) begin
      if (valid[i] && (ids[i] == lookup_id)) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  // Next population count; insert and remove are never issued together
  always_comb begin
    cnt_next_c = cnt;
    if (insert)      cnt_next_c = cnt + CNT_W'(1);
    else if (remove) cnt_next_c = cnt - CNT_W'(1);
  end

  // Entry valid bits and population count
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      cnt   <= '0;
    end else begin
      if (insert) valid[insert_idx] <= 1'b1;
      if (remove) valid[remove_idx] <= 1'b0;
      cnt <= cnt_next_c;
    end
  end

  // Entry ids are only meaningful while valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (insert && !rst) ids[insert_idx] <= insert_id;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scancode decoder with multi-key held table and make/break/repeat events.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned MAX_KEYS      = 4,
  parameter bit          REPORT_REPEAT = 1'b0,
  parameter int unsigned CNT_W         = $clog2(MAX_KEYS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data_in,
  output logic             ev_valid,
  output logic             ev_make,
  output logic             ev_repeat,
  output logic             ev_ext,
  output logic [7:0]       ev_code,
  output logic [CNT_W-1:0] held_cnt,
  output logic             any_pressed,
  output logic             overflow,
  output logic [7:0]       last_code
);

  localparam int unsigned IDX_W = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  ps2_state_e       state;
  logic             ext_c, brk_c, prefix_c, ignored_c, final_c;
  logic             make_c, break_c, insert_c, remove_c;
  key_id_t          id_c;
  logic             hit_c, free_c;
  logic [IDX_W-1:0] hit_idx_c, free_idx_c;
  logic [CNT_W-1:0] cnt_next_c;

  // Byte classification against the current prefix state
  always_comb begin
    ext_c     = (state == EXT) || (state == EXT_BRK);
    brk_c     = (state == BRK) || (state == EXT_BRK);
    ignored_c = is_ignored(data_in);
    prefix_c  = (data_in == PS2_EXT) || (data_in == PS2_BRK);
    final_c   = ready && !ignored_c && !prefix_c;
    make_c    = final_c && !brk_c;
    break_c   = final_c && brk_c;
    id_c      = {ext_c, data_in};
    insert_c  = make_c && !hit_c && free_c;
    remove_c  = break_c && hit_c;
  end

  ps2_key_table #(
    .MAX_KEYS (MAX_KEYS),
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .lookup_id  (id_c),
    .hit_c      (hit_c),
    .hit_idx_c  (hit_idx_c),
    .free_c     (free_c),
    .free_idx_c (free_idx_c),
    .insert     (insert_c),
    .insert_idx (free_idx_c),
    .insert_id  (id_c),
    .remove     (remove_c),
    .remove_idx (hit_idx_c),
    .cnt        (held_cnt),
    .cnt_next_c (cnt_next_c)
  );

  // Prefix FSM, one-cycle event pulse and sticky status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ev_valid    <= 1'b0;
      ev_make     <= 1'b0;
      ev_repeat   <= 1'b0;
      ev_ext      <= 1'b0;
      ev_code     <= '0;
      any_pressed <= 1'b0;
      overflow    <= 1'b0;
      last_code   <= '0;
    end else begin
      ev_valid    <= 1'b0;
      ev_make     <= 1'b0;
      ev_repeat   <= 1'b0;
      ev_ext      <= 1'b0;
      ev_code     <= '0;
      any_pressed <= (cnt_next_c != '0);

      if (cnt_next_c == '0)                 overflow <= 1'b0;
      else if (make_c && !hit_c && !free_c) overflow <= 1'b1;

      if (ready) begin
        if (ignored_c)                state <= IDLE;
        else if (data_in == PS2_EXT)  state <= brk_c ? EXT_BRK : EXT;
        else if (data_in == PS2_BRK)  state <= ext_c ? EXT_BRK : BRK;
        else                          state <= IDLE;
      end

      if (make_c && (!hit_c || REPORT_REPEAT)) begin
        ev_valid  <= 1'b1;
        ev_make   <= 1'b1;
        ev_repeat <= hit_c;
        ev_ext    <= ext_c;
        ev_code   <= data_in;
      end
      if (make_c && !hit_c) last_code <= data_in;

      if (break_c) begin
        ev_valid <= 1'b1;
        ev_ext   <= ext_c;
        ev_code  <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: two instances (repeats suppressed / reported).
module tb_ps2_key_tracker;

  localparam int unsigned MAXK = 4;
  localparam int unsigned CW   = $clog2(MAXK + 1);

  typedef struct packed {
    logic       mk;
    logic       rp;
    logic       ext;
    logic [7:0] code;
    logic [3:0] cnt;
    logic       ovf;
    logic [7:0] last;
  } exp_t;

  typedef logic [7:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready = 1'b0;
  logic [7:0]    data_in = 8'h00;

  logic          ev_valid0, ev_make0, ev_repeat0, ev_ext0, any_pressed0, overflow0;
  logic [7:0]    ev_code0, last_code0;
  logic [CW-1:0] held_cnt0;
  logic          ev_valid1, ev_make1, ev_repeat1, ev_ext1, any_pressed1, overflow1;
  logic [7:0]    ev_code1, last_code1;
  logic [CW-1:0] held_cnt1;

  always #5 clk = ~clk;

  ps2_key_tracker #(.MAX_KEYS(MAXK), .REPORT_REPEAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .ready(ready), .data_in(data_in),
    .ev_valid(ev_valid0), .ev_make(ev_make0), .ev_repeat(ev_repeat0), .ev_ext(ev_ext0),
    .ev_code(ev_code0), .held_cnt(held_cnt0), .any_pressed(any_pressed0),
    .overflow(overflow0), .last_code(last_code0)
  );

  ps2_key_tracker #(.MAX_KEYS(MAXK), .REPORT_REPEAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .ready(ready), .data_in(data_in),
    .ev_valid(ev_valid1), .ev_make(ev_make1), .ev_repeat(ev_repeat1), .ev_ext(ev_ext1),
    .ev_code(ev_code1), .held_cnt(held_cnt1), .any_pressed(any_pressed1),
    .overflow(overflow1), .last_code(last_code1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0 [$];
  exp_t q1 [$];

  // Reference model state per instance (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK)
  bit         pres  [2][512];
  int         cnt_m [2];
  bit         ovf_m [2];
  logic [7:0] last_m[2];
  int         st_m  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 512; i++) pres[k][i] = 1'b0;
      cnt_m[k]  = 0;
      ovf_m[k]  = 1'b0;
      last_m[k] = 8'h00;
      st_m[k]   = 0;
    end
  endfunction

  function automatic void push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void model_step(input int k, input logic [7:0] b);
    exp_t e;
    bit   ext, brk;
    int   id;
    if (b inside {8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      st_m[k] = 0;
      return;
    end
    if (b == 8'hE0) begin
      st_m[k] = (st_m[k] >= 2) ? 3 : 1;
      return;
    end
    if (b == 8'hF0) begin
      st_m[k] = (st_m[k] == 1 || st_m[k] == 3) ? 3 : 2;
      return;
    end
    ext = (st_m[k] == 1) || (st_m[k] == 3);
    brk = (st_m[k] >= 2);
    id  = (ext ? 256 : 0) + int'(b);
    st_m[k] = 0;
    e = '0;
    e.ext  = ext;
    e.code = b;
    if (!brk) begin
      if (pres[k][id]) begin
        if (k == 1) begin
          e.mk = 1'b1;
          e.rp = 1'b1;
        end else return;
      end else begin
        if (cnt_m[k] < int'(MAXK)) begin
          pres[k][id] = 1'b1;
          cnt_m[k]++;
        end else ovf_m[k] = 1'b1;
        last_m[k] = b;
        e.mk = 1'b1;
      end
    end else begin
      if (pres[k][id]) begin
        pres[k][id] = 1'b0;
        cnt_m[k]--;
        if (cnt_m[k] == 0) ovf_m[k] = 1'b0;
      end
    end
    e.cnt  = 4'(cnt_m[k]);
    e.ovf  = ovf_m[k];
    e.last = last_m[k];
    push(k, e);
  endfunction

  task automatic mon(input int k, input logic v, input logic mk, input logic rp, input logic ex,
                     input logic [7:0] code, input logic [CW-1:0] cnt, input logic ap,
                     input logic ov, input logic [7:0] lc);
    exp_t  e;
    string p;
    p = (k == 0) ? "d0" : "d1";
    if (v === 1'b1) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        check({p, ".spurious_ev"}, 32'(1), 32'(0));
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check({p, ".ev_make"},     32'(mk),   32'(e.mk));
        check({p, ".ev_repeat"},   32'(rp),   32'(e.rp));
        check({p, ".ev_ext"},      32'(ex),   32'(e.ext));
        check({p, ".ev_code"},     32'(code), 32'(e.code));
        check({p, ".held_cnt"},    32'(cnt),  32'(e.cnt));
        check({p, ".overflow"},    32'(ov),   32'(e.ovf));
        check({p, ".last_code"},   32'(lc),   32'(e.last));
        check({p, ".any_pressed"}, 32'(ap),   32'(e.cnt != 4'd0));
      end
    end else if (!rst && ({mk, rp, ex, code} !== 11'd0)) begin
      check({p, ".idle_fields"}, 32'({mk, rp, ex, code}), 32'(0));
    end
  endtask

  // Events are sampled mid-cycle, half a period after the registering edge
  always @(negedge clk) begin
    mon(0, ev_valid0, ev_make0, ev_repeat0, ev_ext0, ev_code0, held_cnt0, any_pressed0,
        overflow0, last_code0);
    mon(1, ev_valid1, ev_make1, ev_repeat1, ev_ext1, ev_code1, held_cnt1, any_pressed1,
        overflow1, last_code1);
  end

  task automatic drive(input logic [7:0] b);
    ready   = 1'b1;
    data_in = b;
    model_step(0, b);
    model_step(1, b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ready   = 1'b0;
    data_in = 8'h00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input byte_q_t s);
    foreach (s[i]) drive(s[i]);
    idle(2);
  endtask

  task automatic status(input string tag);
    check({"d0.", tag, ".held_cnt"},    32'(held_cnt0),    32'(cnt_m[0]));
    check({"d0.", tag, ".overflow"},    32'(overflow0),    32'(ovf_m[0]));
    check({"d0.", tag, ".last_code"},   32'(last_code0),   32'(last_m[0]));
    check({"d0.", tag, ".any_pressed"}, 32'(any_pressed0), 32'(cnt_m[0] != 0));
    check({"d1.", tag, ".held_cnt"},    32'(held_cnt1),    32'(cnt_m[1]));
    check({"d1.", tag, ".overflow"},    32'(overflow1),    32'(ovf_m[1]));
  endtask

  byte_q_t s;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.held_cnt",    32'(held_cnt0),    32'(0));
    check("rst.any_pressed", 32'(any_pressed0), 32'(0));
    check("rst.overflow",    32'(overflow0),    32'(0));
    check("rst.last_code",   32'(last_code0),   32'(0));
    check("rst.ev_valid",    32'(ev_valid0),    32'(0));
    rst = 1'b0;
    idle(1);

    // Plain key make/break
    s = '{8'h1C};                 send(s);
    check("plain.held_cnt", 32'(held_cnt0), 32'(1));
    s = '{8'hF0, 8'h1C};          send(s);
    check("plain.last_code", 32'(last_code0), 32'(8'h1C));
    status("plain");

    // Extended key make/break
    s = '{8'hE0, 8'h75};          send(s);
    s = '{8'hE0, 8'hF0, 8'h75};   send(s);
    status("ext");

    // Typematic repeat: dut0 suppresses, dut1 reports
    s = '{8'h1C, 8'h1C, 8'h1C};   send(s);
    check("rep.held_cnt", 32'(held_cnt1), 32'(1));
    s = '{8'hF0, 8'h1C};          send(s);

    // Overflow with a full table
    s = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C}; send(s);
    check("ovf.held_cnt", 32'(held_cnt0), 32'(4));
    check("ovf.overflow", 32'(overflow0), 32'(1));
    status("ovf_full");
    s = '{8'hF0, 8'h15};          send(s);
    check("ovf.sticky", 32'(overflow0), 32'(1));
    status("ovf_one_off");
    s = '{8'hF0, 8'h1D, 8'hF0, 8'h24, 8'hF0, 8'h2D}; send(s);
    check("ovf.cleared", 32'(overflow0), 32'(0));
    s = '{8'hF0, 8'h2C};          send(s);
    status("ovf_empty");

    // Orphan break and ignored byte cancelling a prefix
    s = '{8'hF0, 8'h77};          send(s);
    check("orphan.held_cnt", 32'(held_cnt0), 32'(0));
    s = '{8'hE0, 8'hAA, 8'h1C};   send(s);
    s = '{8'hF0, 8'h1C};          send(s);
    status("robust");

    // Back-to-back strobes
    s = '{8'h1B, 8'h23, 8'hF0, 8'h1B, 8'hF0, 8'h23, 8'hE0, 8'h11, 8'hE0, 8'hF0, 8'h11};
    send(s);
    status("b2b");

    // Reset mid-sequence, with a final byte presented during the reset cycle
    s = '{8'h1C};                 send(s);
    drive(8'hE0);
    drive(8'hF0);
    rst     = 1'b1;
    ready   = 1'b1;
    data_in = 8'h75;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b0;
    model_reset();
    check("rstmid.held_cnt", 32'(held_cnt0), 32'(0));
    check("rstmid.ev_valid", 32'(ev_valid0), 32'(0));
    idle(1);
    s = '{8'h75};                 send(s);
    check("rstmid.last_code", 32'(last_code0), 32'(8'h75));
    status("rstmid");

    // Random stream with gaps, prefixes and status bytes
    begin
      logic [7:0] pool [14];
      pool = '{8'h1C, 8'h1D, 8'h15, 8'h24, 8'h75, 8'h6B, 8'h2C, 8'h2D,
               8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hE1, 8'hFA};
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(3) == 0) idle(1);
        drive(pool[$urandom_range(13)]);
      end
      idle(3);
      status("random");
    end

    check("d0.queue_drained", 32'(q0.size()), 32'(0));
    check("d1.queue_drained", 32'(q1.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 Set-2 scancode decoder and held-key tracker that sits between the PS/2 byte receiver and the keyboard consumers (ASCII mapper, display/counter logic).
- Input is a stream of received bytes.
- Handles the E0 extended prefix and the F0 break prefix.
- Tracks up to MAX_KEYS simultaneously held keys.
- Emits one registered make/break/repeat event per completed scancode sequence.
- Supersedes the single-key make/break flagging with multi-key, extended-key and typematic-repeat support.

Parameters:
MAX_KEYS, 4, number of held-key table entries (1..16)
REPORT_REPEAT, 0, 1 = typematic repeats of an already-held key produce ev_valid with ev_repeat=1; 0 = repeats suppressed
CNT_W, $clog2(MAX_KEYS+1), width of held_cnt (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ready  in  1  one-cycle strobe, data_in valid
data_in  in  8  received scancode byte
ev_valid  out  1  one-cycle event pulse
ev_make  out  1  1 = make/repeat, 0 = break (valid with ev_valid)
ev_repeat  out  1  event is a typematic repeat
ev_ext  out  1  key carried E0 prefix
ev_code  out  8  scancode without prefixes
held_cnt  out  CNT_W  number of keys currently in table
any_pressed  out  1  held_cnt != 0
overflow  out  1  sticky: make arrived with table full
last_code  out  8  ev_code of most recent make (non-repeat) event

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On a rst cycle: all table entries invalid, state IDLE.
  - All outputs 0, including held_cnt, overflow and last_code.
  - rst has priority over ready in the same cycle.
  - rst mid-sequence discards any pending prefix.
- Decoding: a key id is {ext, code}, 9 bits. Only cycles with ready=1 advance the FSM.
- FSM:
  - IDLE: E0 -> EXT; F0 -> BRK; other code -> make(ext=0).
  - EXT: F0 -> EXT_BRK; E0 -> EXT; other -> make(ext=1), IDLE.
  - BRK: E0 -> EXT_BRK; F0 -> BRK; other -> break(ext=0), IDLE.
  - EXT_BRK: E0/F0 -> EXT_BRK; other -> break(ext=1), IDLE.
- Ignored bytes: in any state, E1, 00, AA, EE, FA, FE and FF produce no event, leave the table untouched and return the FSM to IDLE. Pause-key sequences therefore decompose into ordinary 14/77 events.
- Make, id already in table (repeat):
  - No table change.
  - If REPORT_REPEAT=1: ev_valid=1, ev_make=1, ev_repeat=1. Otherwise no event.
  - last_code is unchanged.
- Make, id not in table:
  - Insert the id at the lowest-index free entry, held_cnt+1, ev_valid with ev_make=1, last_code=code.
  - If the table is full: no insert, overflow<=1, event still emitted.
- Break:
  - If the id is present: clear its entry, held_cnt-1.
  - Emit ev_valid, ev_make=0, whether or not the id was present.
  - A break for an absent id does not change held_cnt and does not underflow.
- overflow clears only when held_cnt becomes 0 or on rst.
- Latency: ev_* is registered, asserted the cycle after the ready cycle carrying the final byte, held for exactly one cycle. Prefix bytes never pulse ev_valid. ev_* fields are 0 when ev_valid=0.
- held_cnt, any_pressed and last_code update in the same cycle as ev_valid.
- Back-to-back ready strobes on consecutive cycles are supported with no stall.

Decomposition:
- Package ps2_pkg:
  - Byte constants: PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, plus the status bytes 00, AA, EE, FA, FE, FF.
  - typedef key_id_t (9-bit {ext, code}).
  - FSM state enum: IDLE, EXT, BRK, EXT_BRK.
- Sub-module ps2_key_table (parametrised by MAX_KEYS): per-entry valid+id registers.
  - Combinational lookup outputs: hit, hit_idx, free, free_idx.
  - Insert/remove strobes.
  - Population count.
- ps2_key_tracker contains the FSM, the event registers and the overflow logic.

Test Plan:
- Plain key, stimulus 1C then F0 1C: make event code=1C ext=0, held_cnt=1; then break event, held_cnt=0, last_code=1C.
- Extended key, stimulus E0 75 then E0 F0 75: events ext=1 code=75 (make then break); prefix bytes give no ev_valid pulse.
- Typematic repeat, stimulus 1C 1C 1C with REPORT_REPEAT=0: exactly one event.
  - Same stimulus with REPORT_REPEAT=1: three events, the last two with ev_repeat=1; held_cnt=1 throughout.
- Overflow, MAX_KEYS=4, makes 15 1D 24 2D 2C: fifth make emits an event, overflow=1, held_cnt=4.
  - Break 15: held_cnt=3, overflow still 1.
  - Break the remaining keys: overflow=0 once held_cnt=0.
- Robustness, stimulus F0 77 with no prior make: break event, held_cnt stays 0.
  - Stimulus E0, AA, 1C: make with ext=0.
  - ready on consecutive cycles: no events dropped.
- Reset mid-sequence, stimulus E0 F0, then rst, then 75: make event code=75 ext=0; table empty after rst.
